// File: rtl/sr_bank_writer.sv
// Write initiator for a bank of WIDTH set/reset flip-flops: drives only the bits that must change.
// Optional readback verification with retry is enabled by defining SR_BANK_WRITER_READBACK_EN.
module sr_bank_writer #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 1,
    parameter int MAX_RETRY   = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_valid,
    output logic             o_wr_ready,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_s_out,
    output logic [WIDTH-1:0] o_r_out,
    input  logic [WIDTH-1:0] i_q_in,
    input  logic [WIDTH-1:0] i_qbar_in,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [WIDTH-1:0] o_err_mask
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] COMPUTE = 3'd1;
    localparam logic [2:0] DRIVE   = 3'd2;
    localparam logic [2:0] RELEASE = 3'd3;
    localparam logic [2:0] CHECK   = 3'd4;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nx;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_r;
    logic [HW-1:0]    r_hold;
    logic             r_ready;
    logic             r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_err_mask;
    logic [WIDTH-1:0] w_set_mask;
    logic [WIDTH-1:0] w_rst_mask;
    logic             w_accept;

`ifdef SR_BANK_WRITER_READBACK_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [2:0] POST_RELEASE = CHECK;
    logic [RW-1:0]    r_retry;
    logic [WIDTH-1:0] w_bad;

    assign w_set_mask = r_target & ~i_q_in;
    assign w_rst_mask = ~r_target & i_q_in;
    // A bit is bad if it holds the wrong value or q/qbar are not complementary.
    assign w_bad      = (i_q_in ^ r_target) | ~(i_q_in ^ i_qbar_in);
`else
    localparam logic [2:0] POST_RELEASE = IDLE;
    logic [WIDTH-1:0] r_shadow;
    logic             r_shadow_valid;
    logic             w_unused_readback;

    assign w_unused_readback = ^{i_q_in, i_qbar_in};
    // Until the shadow is known, every bit is forced to its target value.
    assign w_set_mask = r_shadow_valid ? (r_target & ~r_shadow) : r_target;
    assign w_rst_mask = r_shadow_valid ? (~r_target & r_shadow) : ~r_target;
`endif

    assign w_accept   = (r_state == IDLE) && r_ready && i_wr_valid;
    assign o_wr_ready = r_ready;
    assign o_busy     = (r_state != IDLE);
    assign o_s_out    = r_s;
    assign o_r_out    = r_r;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_err_mask = r_err_mask;

    // Next-state selection.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nx = COMPUTE;
                else          w_state_nx = IDLE;
            end
            COMPUTE: begin
                if ((w_set_mask | w_rst_mask) != '0) w_state_nx = DRIVE;
                else                                  w_state_nx = POST_RELEASE;
            end
            DRIVE: begin
                if (r_hold == '0) w_state_nx = RELEASE;
                else              w_state_nx = DRIVE;
            end
            RELEASE: w_state_nx = POST_RELEASE;
            CHECK: begin
`ifdef SR_BANK_WRITER_READBACK_EN
                if ((w_bad != '0) && (r_retry < RW'(MAX_RETRY))) w_state_nx = COMPUTE;
                else                                              w_state_nx = IDLE;
`else
                w_state_nx = IDLE;
`endif
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // State, drive outputs and status pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_ready    <= 1'b0;
            r_target   <= '0;
            r_s        <= '0;
            r_r        <= '0;
            r_hold     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_mask <= '0;
`ifdef SR_BANK_WRITER_READBACK_EN
            r_retry    <= '0;
`else
            r_shadow       <= '0;
            r_shadow_valid <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_ready <= (w_state_nx == IDLE);
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_target   <= i_wr_data;
                        r_err_mask <= '0;
`ifdef SR_BANK_WRITER_READBACK_EN
                        r_retry    <= '0;
`endif
                    end
                end
                COMPUTE: begin
                    if (w_state_nx == DRIVE) begin
                        r_s    <= w_set_mask;
                        r_r    <= w_rst_mask;
                        r_hold <= HW'(HOLD_CYCLES - 1);
                    end
`ifndef SR_BANK_WRITER_READBACK_EN
                    else begin
                        r_done <= 1'b1;
                    end
`endif
                end
                DRIVE: begin
                    if (r_hold == '0) begin
                        r_s <= '0;
                        r_r <= '0;
                    end else begin
                        r_hold <= r_hold - HW'(1);
                    end
                end
                RELEASE: begin
`ifndef SR_BANK_WRITER_READBACK_EN
                    r_shadow       <= r_target;
                    r_shadow_valid <= 1'b1;
                    r_done         <= 1'b1;
`endif
                end
                CHECK: begin
`ifdef SR_BANK_WRITER_READBACK_EN
                    if (w_bad == '0) begin
                        r_done <= 1'b1;
                    end else if (r_retry < RW'(MAX_RETRY)) begin
                        r_retry <= r_retry + RW'(1);
                    end else begin
                        r_err      <= 1'b1;
                        r_err_mask <= w_bad;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_bank_writer.sv
// Self-checking bench for sr_bank_writer with a behavioural flip-flop bank and write-level reference model.
// Follows SR_BANK_WRITER_READBACK_EN the same way the design does.
module tb_sr_bank_writer;

    localparam int HOLD = 1;
    localparam int MAXR = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       o_wr_ready;
    logic [7:0] o_s_out, o_r_out, q_in, qbar_in, o_err_mask;
    logic       o_busy, o_done, o_err;

    logic [7:0] bank = 8'h00;
    logic [7:0] stk0 = 8'h00;
    logic [7:0] bz   = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_sh  = 8'h00;
    bit         m_shv = 1'b0;
    logic [7:0] m_b   = 8'h00;
    logic [7:0] last_w = 8'h00;

    typedef struct {
        logic [7:0] w;
        logic [7:0] s;
        logic [7:0] r;
        int         lat;
    } vec_t;
    vec_t tbl[6];

    sr_bank_writer #(.WIDTH(8), .HOLD_CYCLES(HOLD), .MAX_RETRY(MAXR)) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .o_wr_ready(o_wr_ready),
        .i_wr_data(wr_data), .o_s_out(o_s_out), .o_r_out(o_r_out),
        .i_q_in(q_in), .i_qbar_in(qbar_in), .o_busy(o_busy), .o_done(o_done),
        .o_err(o_err), .o_err_mask(o_err_mask)
    );

    always #5 clk = ~clk;

    // Flip-flop bank: set wins over hold, reset clears; faults only affect readback.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (o_s_out[i])      bank[i] <= 1'b1;
            else if (o_r_out[i]) bank[i] <= 1'b0;
        end
    end
    assign q_in    = bank & ~stk0 & ~bz;
    assign qbar_in = ~q_in & ~bz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) chk("s_and_r_disjoint", {24'h0, o_s_out & o_r_out}, 32'h0);
    end

    // Reference: outcome of one write derived from the set/reset rules on whole words.
    task automatic model_write(input logic [7:0] w, output logic [7:0] es, output logic [7:0] er,
                               output int edrv, output int elat, output bit edone, output bit eerr,
                               output logic [7:0] emask);
        logic [7:0] qr, qb, st, rs, bad;
        es = 8'h00; er = 8'h00; edrv = 0; elat = 0; edone = 1'b0; eerr = 1'b0; emask = 8'h00;
`ifdef SR_BANK_WRITER_READBACK_EN
        for (int a = 0; a <= MAXR; a++) begin
            elat++;
            qr = m_b & ~stk0 & ~bz;
            st = w & ~qr;
            rs = ~w & qr;
            if ((st | rs) != 8'h00) begin
                edrv += HOLD;
                es |= st;
                er |= rs;
                m_b = (m_b | st) & ~rs;
                elat += HOLD + 1;
            end
            elat++;
            qr  = m_b & ~stk0 & ~bz;
            qb  = ~qr & ~bz;
            bad = (qr ^ w) | ~(qr ^ qb);
            if (bad == 8'h00) begin
                edone = 1'b1;
                break;
            end
            if (a == MAXR) begin
                eerr  = 1'b1;
                emask = bad;
            end
        end
        elat++;
`else
        if (!m_shv) begin
            es = w;
            er = ~w;
        end else begin
            es = w & ~m_sh;
            er = ~w & m_sh;
        end
        if ((es | er) == 8'h00) begin
            elat = 2;
        end else begin
            edrv = HOLD;
            elat = 3 + HOLD;
        end
        m_sh  = w;
        m_shv = 1'b1;
        edone = 1'b1;
        qr = 8'h00; qb = 8'h00; st = 8'h00; rs = 8'h00; bad = 8'h00;
`endif
    endtask

    task automatic do_write(input logic [7:0] w, output int lat, output int drv, output logic [7:0] s_seen,
                            output logic [7:0] r_seen, output bit got_done, output bit got_err,
                            output int busy_cyc, output int ready_cyc);
        int wait_n = 0;
        lat = -1; drv = 0; s_seen = 8'h00; r_seen = 8'h00;
        got_done = 1'b0; got_err = 1'b0; busy_cyc = 0; ready_cyc = 0;
        while (!o_wr_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        wr_valid = 1'b1;
        wr_data  = w;
        @(posedge clk);
        #1;
        wr_valid = 1'($urandom_range(0, 1));
        wr_data  = 8'($urandom);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (o_done || o_err) begin
                got_done = o_done;
                got_err  = o_err;
                lat      = k;
                break;
            end
            if (o_busy) busy_cyc++;
            if (o_wr_ready) ready_cyc++;
            if ((o_s_out | o_r_out) != 8'h00) begin
                drv++;
                s_seen |= o_s_out;
                r_seen |= o_r_out;
            end
        end
        wr_valid = 1'b0;
        last_w   = w;
    endtask

    task automatic cmp_write(input string name, input logic [7:0] w, input logic [7:0] es, input logic [7:0] er,
                             input int edrv, input int elat, input bit edone, input bit eerr,
                             input logic [7:0] emask);
        int lat, drv, bc, rc;
        logic [7:0] ss, rr;
        bit gd, ge;
        do_write(w, lat, drv, ss, rr, gd, ge, bc, rc);
        chk({name, ".latency"}, lat, elat);
        chk({name, ".drive_cycles"}, drv, edrv);
        chk({name, ".s_out"}, {24'h0, ss}, {24'h0, es});
        chk({name, ".r_out"}, {24'h0, rr}, {24'h0, er});
        chk({name, ".done"}, {31'h0, gd}, {31'h0, edone});
        chk({name, ".err"}, {31'h0, ge}, {31'h0, eerr});
        chk({name, ".err_mask"}, {24'h0, o_err_mask}, {24'h0, emask});
        chk({name, ".busy_cycles"}, bc, elat - 1);
        chk({name, ".ready_while_busy"}, rc, 0);
        if (edone && stk0 == 8'h00 && bz == 8'h00) chk({name, ".bank"}, {24'h0, bank}, {24'h0, w});
    endtask

    task automatic model_and_check(input string name, input logic [7:0] w);
        logic [7:0] es, er, em;
        int ed, el;
        bit dn, er_b;
        model_write(w, es, er, ed, el, dn, er_b, em);
        cmp_write(name, w, es, er, ed, el, dn, er_b, em);
    endtask

    initial begin
        logic [7:0] es, er, em, w;
        int ed, el;
        bit dn, eb, got;

`ifdef SR_BANK_WRITER_READBACK_EN
        tbl[0] = '{8'hA5, 8'hA5, 8'h00, 5};
        tbl[1] = '{8'hA5, 8'h00, 8'h00, 3};
        tbl[2] = '{8'h3C, 8'h18, 8'h81, 5};
        tbl[3] = '{8'h3C, 8'h00, 8'h00, 3};
        tbl[4] = '{8'h00, 8'h00, 8'h3C, 5};
        tbl[5] = '{8'hFF, 8'hFF, 8'h00, 5};
`else
        tbl[0] = '{8'hA5, 8'hA5, 8'h5A, 4};
        tbl[1] = '{8'hA5, 8'h00, 8'h00, 2};
        tbl[2] = '{8'h3C, 8'h18, 8'h81, 4};
        tbl[3] = '{8'h3C, 8'h00, 8'h00, 2};
        tbl[4] = '{8'h00, 8'h00, 8'h3C, 4};
        tbl[5] = '{8'hFF, 8'hFF, 8'h00, 4};
`endif

        rst = 1'b1;
        wr_valid = 1'b0;
        wr_data = 8'h00;
        #2;
        chk("reset.s_out", {24'h0, o_s_out}, 32'h0);
        chk("reset.r_out", {24'h0, o_r_out}, 32'h0);
        chk("reset.busy", {31'h0, o_busy}, 32'h0);
        chk("reset.ready", {31'h0, o_wr_ready}, 32'h0);
        chk("reset.done", {31'h0, o_done}, 32'h0);
        chk("reset.err", {31'h0, o_err}, 32'h0);
        chk("reset.err_mask", {24'h0, o_err_mask}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.ready_before_edge", {31'h0, o_wr_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("reset.ready_after_edge", {31'h0, o_wr_ready}, 32'h1);
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            model_write(tbl[i].w, es, er, ed, el, dn, eb, em);
            cmp_write($sformatf("vec%0d", i), tbl[i].w, tbl[i].s, tbl[i].r,
                      ((tbl[i].s | tbl[i].r) != 8'h00) ? HOLD : 0, tbl[i].lat, 1'b1, 1'b0, 8'h00);
        end

        for (int i = 0; i < 24; i++) begin
            w = (i % 4 == 3) ? last_w : 8'($urandom);
            model_and_check($sformatf("rand%0d", i), w);
        end

        // Reset arriving mid-drive must abandon the write with no clock edge.
        wr_valid = 1'b1;
        wr_data  = ~last_w;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if ((o_s_out | o_r_out) != 8'h00) begin
                got = 1'b1;
                break;
            end
        end
        chk("rstmid.reached_drive", {31'h0, got}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid.s_out", {24'h0, o_s_out}, 32'h0);
        chk("rstmid.r_out", {24'h0, o_r_out}, 32'h0);
        chk("rstmid.busy", {31'h0, o_busy}, 32'h0);
        chk("rstmid.ready", {31'h0, o_wr_ready}, 32'h0);
        chk("rstmid.done", {31'h0, o_done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid.ready_before_edge", {31'h0, o_wr_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("rstmid.ready_after_edge", {31'h0, o_wr_ready}, 32'h1);
        @(negedge clk);
        m_shv = 1'b0;
        m_b   = bank;
        model_and_check("after_rst", ~last_w);
        model_and_check("after_rst2", 8'h5A);

`ifdef SR_BANK_WRITER_READBACK_EN
        model_and_check("rb_clear", 8'h00);
        stk0 = 8'h01;
        model_and_check("stuck0", 8'h01);
        chk("stuck0.err_mask_const", {24'h0, o_err_mask}, 32'h01);
        stk0 = 8'h00;
        model_and_check("stuck0_recover", 8'h00);
        bz = 8'h80;
        model_and_check("qqbar_low", 8'h00);
        chk("qqbar_low.err_mask_const", {24'h0, o_err_mask}, 32'h80);
        bz = 8'h00;
        model_and_check("qqbar_recover", 8'h3C);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
